wb_mem_responder: RTL

Pipelined Wishbone B4 slave that terminates a bus with an internal word-addressed memory, returning exactly one ACK or ERR per accepted strobe after a fixed, parameterised latency. It is the responder counterpart of the bus checker and master models in the simulation environment. It gives masters under test a well-behaved target with controllable latency, bounded outstanding requests and STALL back-pressure. It is synthesizable RTL: no simulation-only constructs.

---
 rtl/wb_resp_pkg.sv | 24 ++
 rtl/wb_resp_delay.sv | 30 +++
 rtl/wb_mem_responder.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_resp_pkg.sv
// Shared types and address-decode helpers for the Wishbone memory responder.
// The response record carries everything the output stage needs, so the delay line stays generic.
package wb_resp_pkg;

    localparam int WB_DW = 32;

    typedef struct packed {
        logic             valid;
        logic             err;
        logic             we;
        logic [WB_DW-1:0] data;
    } wb_resp_t;

    function automatic logic [63:0] wb_word_index(input logic [63:0] adr, input int unsigned off_w);
        return adr >> off_w;
    endfunction

    function automatic logic wb_misaligned(input logic [63:0] adr, input int unsigned off_w);
        logic [63:0] mask;
        mask = (64'd1 << off_w) - 64'd1;
        return (adr & mask) != 64'd0;
    endfunction

endpackage

// File: rtl/wb_resp_delay.sv
// Fixed-length delay line for accepted requests; flush kills every in-flight entry.
// Only the valid bits are cleared, the payload simply shifts along behind them.
module wb_resp_delay
    import wb_resp_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic     clk,
    input  logic     flush_i,
    input  wb_resp_t resp_i,
    output wb_resp_t resp_o
);

    wb_resp_t stage_q [LATENCY];

    always_ff @(posedge clk) begin
        stage_q[0] <= resp_i;
        for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
        if (flush_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 slave backed by a word-addressed memory, one ACK/ERR per accepted strobe
// after LATENCY cycles, with outstanding-request limit enforced through STALL.
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cyc,
    input  logic            stb,
    input  logic            we,
    input  logic [AW-1:0]   adr,
    input  logic [DW/8-1:0] sel,
    input  logic [DW-1:0]   dat_m,
    output logic [DW-1:0]   dat_s,
    output logic            ack,
    output logic            err,
    output logic            stall
);

    localparam int          BW    = DW / 8;
    localparam int unsigned OFF_W = $clog2(BW);
    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam int          CNT_W = $clog2(MAX_OUT + 1);

    logic [DW-1:0]    mem_q [MEM_WORDS];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      adr_ext;
    logic [63:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             bad_adr;
    logic             accept;
    logic             flush;
    logic             resp_fire;
    logic             out_en;
    wb_resp_t         req;
    wb_resp_t         resp;

    assign adr_ext  = 64'(adr);
    assign word_idx = wb_word_index(adr_ext, OFF_W);
    assign bad_adr  = (word_idx >= 64'(MEM_WORDS)) || wb_misaligned(adr_ext, OFF_W);
    assign mem_idx  = word_idx[IDX_W-1:0];

    // A dropped cycle and reset both abandon every in-flight response.
    assign flush  = rst || !cyc;
    assign stall  = (cnt_q == CNT_W'(MAX_OUT)) && !rst;
    assign accept = cyc && stb && !stall && !rst;

    always_comb begin
        req       = '0;
        req.valid = accept;
        req.err   = bad_adr;
        req.we    = we;
        if (!we && !bad_adr) begin
            req.data = WB_DW'(mem_q[mem_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && we && !bad_adr) begin
            for (int b = 0; b < BW; b++) begin
                if (sel[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= dat_m[b*8 +: 8];
                end
            end
        end
    end

    wb_resp_delay #(
        .LATENCY(LATENCY)
    ) u_delay (
        .clk     (clk),
        .flush_i (flush),
        .resp_i  (req),
        .resp_o  (resp)
    );

    assign resp_fire = resp.valid;

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, resp_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Final delay stage is the output register; gating keeps the bus quiet while CYC is low.
    assign out_en = resp.valid && cyc && !rst;
    assign ack    = out_en && !resp.err;
    assign err    = out_en && resp.err;
    assign dat_s  = (ack && !resp.we) ? resp.data[DW-1:0] : '0;

endmodule
